// File: rtl/wb_spi_arbiter_pkg.sv
// Shared types and helpers for the Wishbone-to-SPI bridge arbiter.
//   - arb_state_t : arbiter FSM states
//   - WB_ADR_W / WB_DAT_W : default Wishbone address/data widths
//   - cnt_width() : width of the watchdog counter for a given TIMEOUT
//   - idx_width() : width of a master index for a given master count
package wb_arb_pkg;

  localparam int WB_ADR_W = 8;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  // A TIMEOUT of 0 disables the watchdog; keep a 1-bit counter so the
  // declarations stay legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_spi_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per master
//   last : index of the previous owner; search starts at last+1 and wraps
//   gnt  : one-hot winner
//   idx  : binary index of the winner
//   vld  : at least one request present
module rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IDX_W = idx_width(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_M-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    // Offsets 1..NUM_M visit every master once, ending on last itself.
    for (int k = 1; k <= NUM_M; k++) begin
      cand = (int'(last) + k) % NUM_M;
      if (!vld && req[cand]) begin
        vld       = 1'b1;
        idx       = IDX_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_spi_arbiter.sv
// Arbiter sharing one Wishbone-to-SPI bridge slave between NUM_M masters.
// A master owns the bridge for its whole CYC phase so multi-command EEPROM
// sequences (WREN / WRITE / RDSR poll) run uninterrupted.
//   CLK_I, RST_I            : clock, synchronous active-high reset
//   M_CYC_I/M_STB_I/M_WE_I  : per-master Wishbone control
//   M_ADR_I/M_DAT_I         : packed per-master address / write data
//   M_DAT_O                 : read data broadcast (valid with owner's ACK)
//   M_ACK_O/M_ERR_O         : per-master ACK, 1-cycle ERR on watchdog abort
//   S_*                     : bridge-side Wishbone master port
//   GNT_O                   : one-hot current owner
//   BUSY_O                  : high while a master owns or is being recovered
module wb_spi_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_M-1:0]       M_CYC_I,
  input  logic [NUM_M-1:0]       M_STB_I,
  input  logic [NUM_M-1:0]       M_WE_I,
  input  logic [NUM_M*ADR_W-1:0] M_ADR_I,
  input  logic [NUM_M*DAT_W-1:0] M_DAT_I,
  output logic [DAT_W-1:0]       M_DAT_O,
  output logic [NUM_M-1:0]       M_ACK_O,
  output logic [NUM_M-1:0]       M_ERR_O,
  output logic                   S_CYC_O,
  output logic                   S_STB_O,
  output logic                   S_WE_O,
  output logic [ADR_W-1:0]       S_ADR_O,
  output logic [DAT_W-1:0]       S_DAT_O,
  input  logic [DAT_W-1:0]       S_DAT_I,
  input  logic                   S_ACK_I,
  output logic [NUM_M-1:0]       GNT_O,
  output logic                   BUSY_O
);

  localparam int IDX_W = idx_width(NUM_M);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_M - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last;
  logic [NUM_M-1:0] gnt;
  logic [CNT_W-1:0] cnt;

  logic [NUM_M-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  logic owner_cyc;
  logic owner_stb;
  logic stall;
  logic timeout_hit;

  rr_picker #(
    .NUM_M(NUM_M),
    .IDX_W(IDX_W)
  ) u_picker (
    .req (M_CYC_I),
    .last(last),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign owner_cyc = M_CYC_I[owner];
  assign owner_stb = M_STB_I[owner];

  // A stalled cycle is one where the owner strobes and the bridge is silent.
  // cnt holds the number of stalled cycles already elapsed, so the abort
  // fires during the TIMEOUT-th consecutive stalled cycle.
  assign stall       = (state == OWNED) && owner_stb && !S_ACK_I;
  assign timeout_hit = (TIMEOUT > 0) && stall && (cnt == CNT_LAST);

  // State and bookkeeping registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      owner <= '0;
      last  <= LAST_RST;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) begin
        owner <= pick_idx;
        gnt   <= pick_gnt;
      end
      if (state != IDLE && !owner_cyc) begin
        last <= owner;
        gnt  <= '0;
      end
      if ((TIMEOUT > 0) && stall && !timeout_hit) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Next-state logic; a released CYC wins over a simultaneous timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = OWNED;
      end
      OWNED: begin
        if (!owner_cyc)       state_nxt = IDLE;
        else if (timeout_hit) state_nxt = RECOVER;
      end
      RECOVER: begin
        if (!owner_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: bridge signals and ACK are a pure mux while OWNED, so the
  // owner sees the bridge with no added latency once granted.
  always_comb begin
    S_CYC_O = 1'b0;
    S_STB_O = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    M_DAT_O = '0;
    M_ACK_O = '0;
    M_ERR_O = '0;
    if (state == OWNED) begin
      S_CYC_O        = owner_cyc;
      S_STB_O        = owner_stb;
      S_WE_O         = M_WE_I[owner];
      S_ADR_O        = M_ADR_I[int'(owner)*ADR_W +: ADR_W];
      S_DAT_O        = M_DAT_I[int'(owner)*DAT_W +: DAT_W];
      M_DAT_O        = S_DAT_I;
      M_ACK_O[owner] = S_ACK_I & owner_stb;
      M_ERR_O[owner] = timeout_hit;
    end
  end

  assign GNT_O  = gnt;
  assign BUSY_O = (state != IDLE);

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Self-checking bench for wb_spi_arbiter (2 masters, TIMEOUT=16).
// A reference model of ownership (owner index or none, aborted flag,
// stall count, last owner) predicts every output each cycle; table vectors
// and directed sequences add explicit checks for grant timing, locking,
// timeout and reset.
module tb_wb_spi_arbiter;

  localparam int NUM_M = 2;
  localparam int ADR_W = 8;
  localparam int DAT_W = 32;
  localparam int TO    = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_M-1:0]       mcyc, mstb, mwe;
  logic [NUM_M*ADR_W-1:0] madr;
  logic [NUM_M*DAT_W-1:0] mdat;
  logic [DAT_W-1:0]       m_dat_o;
  logic [NUM_M-1:0]       m_ack_o, m_err_o;
  logic                   s_cyc_o, s_stb_o, s_we_o;
  logic [ADR_W-1:0]       s_adr_o;
  logic [DAT_W-1:0]       s_dat_o;
  logic [DAT_W-1:0]       sdat;
  logic                   sack;
  logic [NUM_M-1:0]       gnt_o;
  logic                   busy_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  wb_spi_arbiter #(
    .NUM_M(NUM_M), .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TO)
  ) dut (
    .CLK_I(clk), .RST_I(rst),
    .M_CYC_I(mcyc), .M_STB_I(mstb), .M_WE_I(mwe),
    .M_ADR_I(madr), .M_DAT_I(mdat),
    .M_DAT_O(m_dat_o), .M_ACK_O(m_ack_o), .M_ERR_O(m_err_o),
    .S_CYC_O(s_cyc_o), .S_STB_O(s_stb_o), .S_WE_O(s_we_o),
    .S_ADR_O(s_adr_o), .S_DAT_O(s_dat_o),
    .S_DAT_I(sdat), .S_ACK_I(sack),
    .GNT_O(gnt_o), .BUSY_O(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input logic [1:0] want, input string nm);
    int w;
    w = 0;
    @(negedge clk);
    while (gnt_o !== want && w < 20) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      w++;
    end
    check(nm, 64'(gnt_o), 64'(want));
  endtask

  // ---------------- reference model ----------------
  int md_owner = -1;   // -1: no owner
  bit md_abort = 1'b0; // owner was timed out, waiting for its CYC drop
  int md_last  = NUM_M - 1;
  int md_stall = 0;    // consecutive stalled cycles of the owner

  always @(posedge clk) begin
    if (rst) begin
      md_owner = -1; md_abort = 1'b0; md_last = NUM_M - 1; md_stall = 0;
    end else if (md_owner < 0) begin
      for (int k = 1; k <= NUM_M; k++) begin
        int c;
        c = (md_last + k) % NUM_M;
        if (md_owner < 0 && mcyc[c]) begin
          md_owner = c;
          md_stall = 0;
        end
      end
    end else if (!mcyc[md_owner]) begin
      md_last = md_owner; md_owner = -1; md_abort = 1'b0; md_stall = 0;
    end else if (!md_abort) begin
      if (mstb[md_owner] && !sack) begin
        md_stall++;
        if (md_stall == TO) begin
          md_abort = 1'b1;
          md_stall = 0;
        end
      end else begin
        md_stall = 0;
      end
    end
  end

  logic             e_scyc, e_sstb, e_swe, e_busy;
  logic [ADR_W-1:0] e_sadr;
  logic [DAT_W-1:0] e_sdat, e_mdat;
  logic [NUM_M-1:0] e_mack, e_err, e_gnt;

  always @(negedge clk) begin
    if (chk_en) begin
      e_scyc = 0; e_sstb = 0; e_swe = 0; e_sadr = '0; e_sdat = '0;
      e_mdat = '0; e_mack = '0; e_err = '0;
      e_gnt  = (md_owner >= 0) ? NUM_M'(1 << md_owner) : '0;
      e_busy = (md_owner >= 0);
      if (md_owner >= 0 && !md_abort) begin
        e_scyc = mcyc[md_owner];
        e_sstb = mstb[md_owner];
        e_swe  = mwe[md_owner];
        e_sadr = madr[md_owner*ADR_W +: ADR_W];
        e_sdat = mdat[md_owner*DAT_W +: DAT_W];
        e_mdat = sdat;
        e_mack[md_owner] = sack & mstb[md_owner];
        e_err[md_owner]  = mstb[md_owner] && !sack && (md_stall == TO - 1);
      end
      check("s_cyc", 64'(s_cyc_o), 64'(e_scyc));
      check("s_stb", 64'(s_stb_o), 64'(e_sstb));
      check("s_we",  64'(s_we_o),  64'(e_swe));
      check("s_adr", 64'(s_adr_o), 64'(e_sadr));
      check("s_dat", 64'(s_dat_o), 64'(e_sdat));
      check("m_dat", 64'(m_dat_o), 64'(e_mdat));
      check("m_ack", 64'(m_ack_o), 64'(e_mack));
      check("m_err", 64'(m_err_o), 64'(e_err));
      check("gnt",   64'(gnt_o),   64'(e_gnt));
      check("busy",  64'(busy_o),  64'(e_busy));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] cyc, stb, we;
    logic       ack;
    logic       e_scyc, e_sstb, e_swe;
    logic [7:0] e_sadr;
    logic [1:0] e_mack, e_gnt;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] cyc, stb, we, input logic ack,
                              input logic ec, es, ew, input logic [7:0] ea,
                              input logic [1:0] ek, eg, input logic eb);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack;
    v.e_scyc = ec; v.e_sstb = es; v.e_swe = ew; v.e_sadr = ea;
    v.e_mack = ek; v.e_gnt = eg; v.e_busy = eb;
    return v;
  endfunction

  vec_t tbl[16];
  logic [7:0] lock_adr[3];

  initial begin
    // master 0: write adr 1 / read adr 1; master 1 idles at adr 0x22
    tbl[0]  = mk(2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 8'h00, 2'b00, 2'b00, 0);
    tbl[1]  = mk(2'b01, 2'b01, 2'b01, 0, 1, 1, 1, 8'h01, 2'b00, 2'b01, 1);
    tbl[2]  = mk(2'b01, 2'b01, 2'b01, 1, 1, 1, 1, 8'h01, 2'b01, 2'b01, 1);
    tbl[3]  = mk(2'b01, 2'b00, 2'b00, 0, 1, 0, 0, 8'h01, 2'b00, 2'b01, 1);
    tbl[4]  = mk(2'b01, 2'b01, 2'b00, 0, 1, 1, 0, 8'h01, 2'b00, 2'b01, 1);
    tbl[5]  = mk(2'b01, 2'b01, 2'b00, 1, 1, 1, 0, 8'h01, 2'b01, 2'b01, 1);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h01, 2'b00, 2'b01, 1);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 2'b00, 2'b00, 0);
    tbl[8]  = mk(2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 8'h00, 2'b00, 2'b00, 0);
    tbl[9]  = mk(2'b11, 2'b11, 2'b10, 1, 0, 0, 0, 8'h00, 2'b00, 2'b00, 0);
    tbl[10] = mk(2'b11, 2'b11, 2'b10, 1, 1, 1, 1, 8'h22, 2'b10, 2'b10, 1);
    tbl[11] = mk(2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 8'h22, 2'b00, 2'b10, 1);
    tbl[12] = mk(2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 8'h00, 2'b00, 2'b00, 0);
    tbl[13] = mk(2'b01, 2'b01, 2'b00, 0, 1, 1, 0, 8'h01, 2'b00, 2'b01, 1);
    tbl[14] = mk(2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 8'h01, 2'b01, 2'b01, 1);
    tbl[15] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 8'h00, 2'b00, 2'b00, 0);
    lock_adr[0] = 8'h06; lock_adr[1] = 8'h02; lock_adr[2] = 8'h05;

    rst = 1'b1; mcyc = '0; mstb = '0; mwe = '0; sack = 1'b0;
    madr = {8'h22, 8'h01};
    mdat = {32'h1111_2222, 32'h4154_A000};
    sdat = 32'hC0DE_0042;

    // reset state, with requests and a stray ACK present
    next();
    chk_en = 1'b1;
    mcyc = 2'b11; mstb = 2'b11; sack = 1'b1;
    samp();
    check("rst_gnt",   64'(gnt_o),   64'(0));
    check("rst_busy",  64'(busy_o),  64'(0));
    check("rst_s_cyc", 64'(s_cyc_o), 64'(0));
    check("rst_m_ack", 64'(m_ack_o), 64'(0));
    check("rst_m_dat", 64'(m_dat_o), 64'(0));
    check("rst_s_adr", 64'(s_adr_o), 64'(0));

    for (int i = 0; i < 16; i++) begin
      next();
      rst = 1'b0;
      mcyc = tbl[i].cyc; mstb = tbl[i].stb; mwe = tbl[i].we; sack = tbl[i].ack;
      samp();
      check($sformatf("vec%0d_s_cyc", i), 64'(s_cyc_o), 64'(tbl[i].e_scyc));
      check($sformatf("vec%0d_s_stb", i), 64'(s_stb_o), 64'(tbl[i].e_sstb));
      check($sformatf("vec%0d_s_we", i),  64'(s_we_o),  64'(tbl[i].e_swe));
      check($sformatf("vec%0d_s_adr", i), 64'(s_adr_o), 64'(tbl[i].e_sadr));
      check($sformatf("vec%0d_m_ack", i), 64'(m_ack_o), 64'(tbl[i].e_mack));
      check($sformatf("vec%0d_gnt", i),   64'(gnt_o),   64'(tbl[i].e_gnt));
      check($sformatf("vec%0d_busy", i),  64'(busy_o),  64'(tbl[i].e_busy));
      if (i == 5) check("vec5_rd_data", 64'(m_dat_o), 64'(32'hC0DE_0042));
    end

    // simultaneous requests after reset
    next(); rst = 1'b1; mcyc = '0; mstb = '0; sack = 1'b0;
    next(); rst = 1'b0; mcyc = 2'b11; mstb = 2'b11;
    samp(); check("sim_idle_gnt", 64'(gnt_o), 64'(2'b00));
    next(); sack = 1'b1;
    samp(); check("sim_gnt0", 64'(gnt_o), 64'(2'b01));
    check("sim_ack0", 64'(m_ack_o), 64'(2'b01));
    next(); mcyc = 2'b10; mstb = 2'b10;
    samp(); check("sim_drop_gnt", 64'(gnt_o), 64'(2'b01));
    check("sim_m1_noack_a", 64'(m_ack_o), 64'(2'b00));
    next();
    samp(); check("sim_dead_gnt", 64'(gnt_o), 64'(2'b00));
    check("sim_m1_noack_b", 64'(m_ack_o), 64'(2'b00));
    next();
    samp(); check("sim_gnt1", 64'(gnt_o), 64'(2'b10));
    check("sim_ack1", 64'(m_ack_o), 64'(2'b10));
    next(); mcyc = 2'b00; mstb = 2'b00; sack = 1'b0;
    next();

    // fairness: both masters request continuously
    next(); mcyc = 2'b11; mstb = 2'b11; sack = 1'b1;
    for (int t = 0; t < 8; t++) begin
      logic [1:0] want;
      want = (t % 2 == 1) ? 2'b10 : 2'b01;
      wait_gnt(want, $sformatf("fair_gnt%0d", t));
      check($sformatf("fair_ack%0d", t), 64'(m_ack_o), 64'(want));
      next(); mcyc = ~want;
      next(); mcyc = (t == 7) ? 2'b00 : 2'b11;
    end
    next(); mstb = 2'b00; sack = 1'b0;

    // locked sequence: master 1 runs three STB phases while master 0 waits
    next(); mcyc = 2'b10;
    wait_gnt(2'b10, "lock_gnt");
    for (int p = 0; p < 3; p++) begin
      next(); mcyc = 2'b11; mstb = 2'b11; madr[15:8] = lock_adr[p];
      mwe = (p < 2) ? 2'b10 : 2'b00; sack = 1'b0;
      samp(); check($sformatf("lock%0d_gnt_a", p), 64'(gnt_o), 64'(2'b10));
      check($sformatf("lock%0d_noack", p), 64'(m_ack_o), 64'(2'b00));
      next(); sack = 1'b1;
      samp(); check($sformatf("lock%0d_gnt_b", p), 64'(gnt_o), 64'(2'b10));
      check($sformatf("lock%0d_ack", p), 64'(m_ack_o), 64'(2'b10));
      next(); mstb = 2'b01; sack = 1'b0;
      samp(); check($sformatf("lock%0d_gnt_c", p), 64'(gnt_o), 64'(2'b10));
    end
    next(); mcyc = 2'b01;
    samp(); check("lock_rel_gnt", 64'(gnt_o), 64'(2'b10));
    next();
    samp(); check("lock_dead_gnt", 64'(gnt_o), 64'(2'b00));

    // timeout: master 0 strobes, bridge stays silent
    next();
    samp(); check("to_gnt0", 64'(gnt_o), 64'(2'b01));
    check("to_err_k1", 64'(m_err_o), 64'(2'b00));
    for (int k = 2; k <= 16; k++) begin
      next();
      if (k == 2) mcyc = 2'b11;
      samp(); check($sformatf("to_err_k%0d", k), 64'(m_err_o), 64'((k == 16) ? 2'b01 : 2'b00));
    end
    next(); sack = 1'b1;
    samp(); check("to_s_cyc", 64'(s_cyc_o), 64'(0));
    check("to_s_stb", 64'(s_stb_o), 64'(0));
    check("to_late_ack", 64'(m_ack_o), 64'(2'b00));
    check("to_busy", 64'(busy_o), 64'(1));
    check("to_hold_gnt", 64'(gnt_o), 64'(2'b01));
    next(); mcyc = 2'b10; mstb = 2'b00; sack = 1'b0;
    samp(); check("to_rel_gnt", 64'(gnt_o), 64'(2'b01));
    next();
    samp(); check("to_dead_gnt", 64'(gnt_o), 64'(2'b00));
    next();
    samp(); check("to_next_gnt", 64'(gnt_o), 64'(2'b10));

    // reset in the middle of an owned strobe
    next(); mstb = 2'b10;
    samp(); check("mr_s_stb", 64'(s_stb_o), 64'(1));
    next(); rst = 1'b1;
    next(); rst = 1'b0; mstb = 2'b00;
    samp(); check("mr_gnt", 64'(gnt_o), 64'(0));
    check("mr_busy",  64'(busy_o),  64'(0));
    check("mr_s_cyc", 64'(s_cyc_o), 64'(0));
    check("mr_s_stb", 64'(s_stb_o), 64'(0));
    check("mr_s_adr", 64'(s_adr_o), 64'(0));
    next();
    samp(); check("mr_regnt", 64'(gnt_o), 64'(2'b10));
    next(); mcyc = 2'b00;
    next();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      next();
      rst = ($urandom_range(0, 99) == 0);
      for (int m = 0; m < NUM_M; m++) begin
        if ($urandom_range(0, 11) == 0) mcyc[m] = ~mcyc[m];
        if ($urandom_range(0, 9) == 0)  mstb[m] = ~mstb[m];
      end
      mwe  = 2'($urandom);
      madr = 16'($urandom);
      mdat = {$urandom, $urandom};
      sack = (((n / 64) % 2) == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      sdat = $urandom;
    end

    next();
    chk_en = 1'b0;
    samp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_spi_arbiter.md
Name: wb_spi_arbiter

Overview:
Wishbone arbiter that shares the single Wishbone-to-SPI bridge slave (`top`, driving the 25AA010A EEPROM) between NUM_M Wishbone masters.
- Grants the bridge to one master for the whole of that master's CYC phase. This lets a master run an uninterrupted WREN/WRITE/RDSR-poll sequence.
- Routes ACK and read data back to the owning master only.
- Recovers from a bridge that never ACKs by means of a watchdog.

Parameters:
- NUM_M, 2: number of masters (2..8).
- ADR_W, 8: Wishbone address width.
- DAT_W, 32: Wishbone data width.
- TIMEOUT, 1024: maximum cycles S_STB_O may stay high without S_ACK_I before the grant is aborted; 0 disables the watchdog.

Ports:
- CLK_I  in  1  system clock, all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- M_CYC_I  in  NUM_M  per-master CYC.
- M_STB_I  in  NUM_M  per-master STB.
- M_WE_I  in  NUM_M  per-master WE.
- M_ADR_I  in  NUM_M*ADR_W  packed addresses; master i at [i*ADR_W +: ADR_W].
- M_DAT_I  in  NUM_M*DAT_W  packed write data.
- M_DAT_O  out  DAT_W  read data, broadcast to all masters; valid only with the owner's ACK.
- M_ACK_O  out  NUM_M  per-master ACK.
- M_ERR_O  out  NUM_M  per-master ERR, 1-cycle pulse on timeout.
- S_CYC_O  out  1  to bridge CYC_I.
- S_STB_O  out  1  to bridge STB_I.
- S_WE_O  out  1  to bridge WE_I.
- S_ADR_O  out  ADR_W  to bridge ADR_I.
- S_DAT_O  out  DAT_W  to bridge DAT_I.
- S_DAT_I  in  DAT_W  from bridge DAT_O.
- S_ACK_I  in  1  from bridge ACK_O.
- GNT_O  out  NUM_M  one-hot current owner; all zero when none.
- BUSY_O  out  1  high in OWNED or RECOVER.

Behaviour:
Reset (RST_I high at a clock edge, including mid-transaction):
- state=IDLE, GNT_O=0, BUSY_O=0.
- All M_ACK_O, M_ERR_O, S_CYC_O, S_STB_O, S_WE_O = 0.
- S_ADR_O=0, S_DAT_O=0, M_DAT_O=0.
- Timeout counter=0.
- last=NUM_M-1, so master 0 wins the first arbitration.

States: IDLE, OWNED, RECOVER.

IDLE:
- Slave outputs held 0; all M_ACK_O=0.
- If any M_CYC_I is high at edge n, pick the winner round-robin, searching from last+1 upward with wrap.
- Register the winner into owner and GNT_O; state becomes OWNED.
- S_CYC_O is first high in cycle n+1 (1-cycle grant latency).

OWNED:
- S_CYC_O = M_CYC_I[owner].
- S_STB_O, S_WE_O, S_ADR_O, S_DAT_O = owner's signals, combinational mux.
- M_ACK_O[owner] = S_ACK_I & M_STB_I[owner], combinational. All other M_ACK_O = 0.
- M_DAT_O = S_DAT_I.
- Other masters' requests are ignored; they wait with CYC high.
- The owner may issue any number of STB phases while holding CYC.
- When M_CYC_I[owner] is low at an edge: last=owner, state becomes IDLE, GNT_O=0.
  - One dead cycle follows, so a new grant appears no earlier than 2 cycles after the CYC drop.

Watchdog (OWNED only):
- Counter increments each cycle with S_STB_O=1 and S_ACK_I=0.
- Counter clears on S_ACK_I or when S_STB_O=0.
- When the counter reaches TIMEOUT:
  - M_ERR_O[owner] pulses for 1 cycle.
  - State becomes RECOVER.
  - S_CYC_O and S_STB_O are forced 0 from the next cycle.

RECOVER:
- Slave outputs forced 0; M_ACK_O all 0; S_ACK_I ignored.
- Remain until M_CYC_I[owner]=0, then last=owner and state becomes IDLE.

Boundary conditions:
- A stray S_ACK_I in IDLE or RECOVER is never forwarded.
- An owner dropping CYC in the same cycle as S_ACK_I still receives that ACK.
- NUM_M=1 degenerates to a pass-through with 1-cycle grant latency.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, OWNED, RECOVER), ADR_W/DAT_W defaults, timeout counter width function ($clog2(TIMEOUT+1)).
- Sub-module rr_picker: purely combinational round-robin one-hot picker. Inputs are the request vector and last index; outputs are grant one-hot, index and valid.

Test Plan:
- Single master: master 0 writes adr 1, data 0x4154A000, then reads adr 1.
  - S_CYC_O rises 1 cycle after M_CYC_I[0].
  - Bridge signals match master 0; M_ACK_O[0] pulses; M_ACK_O[1] stays 0.
  - The read returns the bridge data on M_DAT_O.
- Simultaneous: both masters raise CYC on the same edge after reset.
  - Master 0 is granted first.
  - Master 1 is granted 2 cycles after master 0 drops CYC.
  - Master 1 gets no ACK before its grant.
- Fairness: both masters request continuously for 4 transactions each.
  - GNT_O alternates 01,10,01,10,…
- Locked sequence: master 1 holds CYC across 3 STB phases (WREN, write adr 2, RDSR poll) while master 0 requests.
  - Master 0 is never granted until master 1 drops CYC.
- Timeout: TIMEOUT=16, bridge model suppresses ACK.
  - M_ERR_O[owner] pulses at cycle 16 of STB.
  - S_CYC_O is 0 the next cycle.
  - A late ACK is not forwarded.
  - The next master is granted after the owner drops CYC.
- Mid-transaction reset: assert RST_I while OWNED with STB high.
  - The next cycle shows all outputs 0 and GNT_O=0.
  - The post-reset request by master 1 alone is granted normally.
